// File: rtl/pipefft_r2sdf_bfly.sv
// Radix-2 single-path delay-feedback butterfly stage driving an external registered delay RAM.
// Optional halving with round/saturate is enabled by defining PIPEFFT_BFLY_SCALE_EN.
module pipefft_r2sdf_bfly #(
  parameter int DEPTH = 4,
  parameter int DW    = 34,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [2*DW-1:0] in_data,
  output logic            out_valid,
  output logic            out_sof,
  output logic [2*DW-1:0] out_data,
  output logic            err,
  output logic [2*DW-1:0] ram_wD,
  output logic [AW-1:0]   ram_wAddr,
  output logic            ram_wEn,
  output logic [AW-1:0]   ram_rAddr,
  input  logic [2*DW-1:0] ram_rD
);

  typedef enum logic [1:0] {IDLE, FILL, BFLY, DRAIN} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

`ifdef PIPEFFT_BFLY_SCALE_EN
  localparam logic signed [DW:0] SAT_MAX = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] SAT_MIN = {2'b11, {(DW-1){1'b0}}};
`endif

  state_t          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic            pend_q, pend_d;
  logic            start, active, wr, emit, emit_sof, err_d;
  logic [2*DW-1:0] wr_data, emit_data, sum_w, diff_w;

  function automatic logic [DW-1:0] bf(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic sub);
`ifdef PIPEFFT_BFLY_SCALE_EN
    logic signed [DW:0] r, rp, h;
    r  = sub ? ($signed({a[DW-1], a}) - $signed({b[DW-1], b}))
             : ($signed({a[DW-1], a}) + $signed({b[DW-1], b}));
    rp = r + 1;
    h  = rp >>> 1;
    return (h > SAT_MAX) ? SAT_MAX[DW-1:0] :
           (h < SAT_MIN) ? SAT_MIN[DW-1:0] : h[DW-1:0];
`else
    // low DW bits of the full-width result: plain two's-complement wrap
    return sub ? (a - b) : (a + b);
`endif
  endfunction

  assign sum_w  = {bf(ram_rD[2*DW-1:DW], in_data[2*DW-1:DW], 1'b0),
                   bf(ram_rD[DW-1:0],    in_data[DW-1:0],    1'b0)};
  assign diff_w = {bf(ram_rD[2*DW-1:DW], in_data[2*DW-1:DW], 1'b1),
                   bf(ram_rD[DW-1:0],    in_data[DW-1:0],    1'b1)};
  assign start  = in_valid & in_sof;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    active    = 1'b0;
    wr        = 1'b0;
    wr_data   = in_data;
    emit      = 1'b0;
    emit_sof  = 1'b0;
    emit_data = ram_rD;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          cnt_d   = AW'(1);
          active  = 1'b1;
          wr      = 1'b1;
        end
      end
      FILL: begin
        if (!in_valid) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          active = 1'b1;
          wr     = 1'b1;
          err_d  = in_sof;
          emit   = pend_q;
          cnt_d  = cnt_q + AW'(1);
          if (cnt_q == LAST) begin
            state_d = BFLY;
            pend_d  = 1'b0;
          end
        end
      end
      BFLY: begin
        if (!in_valid) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          active    = 1'b1;
          wr        = 1'b1;
          wr_data   = diff_w;
          emit      = 1'b1;
          emit_sof  = (cnt_q == '0);
          emit_data = sum_w;
          err_d     = in_sof;
          cnt_d     = cnt_q + AW'(1);
          if (cnt_q == LAST) begin
            state_d = DRAIN;
            pend_d  = 1'b1;
          end
        end
      end
      DRAIN: begin
        active = 1'b1;
        emit   = 1'b1;
        // first drain cycle doubles as FILL slot 0 of a back-to-back frame
        if (cnt_q == '0 && start) begin
          state_d = FILL;
          cnt_d   = AW'(1);
          wr      = 1'b1;
        end else begin
          err_d = start;
          cnt_d = cnt_q + AW'(1);
          if (cnt_q == LAST) begin
            state_d = IDLE;
            pend_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
    wptr_d = active ? (wptr_q + AW'(1)) : wptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wptr_q    <= '0;
      pend_q    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      ram_wEn   <= 1'b0;
      ram_wAddr <= '0;
      ram_wD    <= '0;
      ram_rAddr <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      pend_q    <= pend_d;
      out_valid <= emit;
      out_sof   <= emit_sof;
      out_data  <= emit ? emit_data : '0;
      err       <= err_d;
      ram_wEn   <= wr;
      ram_wAddr <= wptr_q;
      ram_wD    <= wr ? wr_data : '0;
      // two-cycle read latency: this address returns the entry written DEPTH cycles earlier
      ram_rAddr <= wptr_d + AW'(2);
    end
  end

endmodule

// File: tb/tb_pipefft_r2sdf_bfly.sv
// Scoreboard bench for pipefft_r2sdf_bfly with a registered-address/registered-data delay RAM model.
module tb_pipefft_r2sdf_bfly;
  localparam int DEPTH = 4;
  localparam int DW    = 34;
  localparam int AW    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_sof;
  logic [2*DW-1:0] in_data;
  logic            out_valid, out_sof, err, ram_wEn;
  logic [2*DW-1:0] out_data, ram_wD, ram_rD;
  logic [AW-1:0]   ram_wAddr, ram_rAddr;

  pipefft_r2sdf_bfly #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_sof(out_sof), .out_data(out_data), .err(err),
    .ram_wD(ram_wD), .ram_wAddr(ram_wAddr), .ram_wEn(ram_wEn),
    .ram_rAddr(ram_rAddr), .ram_rD(ram_rD)
  );

  always #5 clk = ~clk;

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   raddr_q;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    raddr_q = '0;
    ram_rD  = '0;
  end
  always @(posedge clk) begin
    if (ram_wEn) mem[ram_wAddr] <= ram_wD;
    raddr_q <= ram_rAddr;
    ram_rD  <= mem[raddr_q];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; bit sof; longint re; longint im;} exp_t;
  exp_t q[$];

  int  n_cmp = 0, n_bad = 0;
  int  err_cnt = 0, err_cyc = -1;
  bit  mon_en = 0;
  longint f_re[8], f_im[8], s_re[4], s_im[4], d_re[4], d_im[4];

  function automatic longint sc(input longint v);
    longint h;
`ifdef PIPEFFT_BFLY_SCALE_EN
    h = (v + 1) >>> 1;
    if (h > 64'sd8589934591) h = 64'sd8589934591;
    if (h < -64'sd8589934592) h = -64'sd8589934592;
`else
    h = v & 64'sh3_FFFF_FFFF;
    if (h >= 64'sd8589934592) h = h - 64'sd17179869184;
`endif
    return h;
  endfunction

  task automatic chk(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic drv(input bit v, input bit s, input longint re, input longint im, input bit r);
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    in_sof   = s;
    in_data  = {im[DW-1:0], re[DW-1:0]};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0);
  endtask

  // drives the first nsamp samples of f_re/f_im; diffs are expected only for a full frame
  task automatic run_frame(input int nsamp);
    int c0;
    exp_t e;
    c0 = 0;
    for (int k = 0; k < nsamp; k++) begin
      drv(1, k == 0, f_re[k], f_im[k], 0);
      if (k == 0) c0 = cyc;
      if (k >= 4) begin
        e.cyc = cyc + 1; e.sof = (k == 4); e.re = sc(s_re[k-4]); e.im = sc(s_im[k-4]);
        q.push_back(e);
      end
      if (k == 7) begin
        for (int j = 0; j < 4; j++) begin
          e.cyc = c0 + 9 + j; e.sof = 0; e.re = sc(d_re[j]); e.im = sc(d_im[j]);
          q.push_back(e);
        end
      end
    end
  endtask

  task automatic ramp(input longint base);
    for (int k = 0; k < 8; k++) begin f_re[k] = base + k; f_im[k] = 0; end
    for (int j = 0; j < 4; j++) begin
      s_re[j] = 2 * base + 4 + 2 * j; s_im[j] = 0; d_re[j] = -4; d_im[j] = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_sof"},   longint'(out_sof), 0);
    chk({tag, "_out_data"},  longint'(out_data != '0), 0);
    chk({tag, "_err"},       longint'(err), 0);
    chk({tag, "_ram_wEn"},   longint'(ram_wEn), 0);
    chk({tag, "_ram_wAddr"}, longint'(ram_wAddr), 0);
    chk({tag, "_ram_rAddr"}, longint'(ram_rAddr), 0);
    chk({tag, "_ram_wD"},    longint'(ram_wD != '0), 0);
  endtask

  initial begin
    exp_t   e;
    longint g_re, g_im;
    int     e0, cbad;
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (err) begin err_cnt++; err_cyc = cyc; end
          if (out_valid) begin
            n_cmp++;
            g_re = longint'($signed(out_data[DW-1:0]));
            g_im = longint'($signed(out_data[2*DW-1:DW]));
            if (q.size() == 0) begin
              n_bad++;
              $display("FAIL out_extra: cyc=%0d re=%0d im=%0d, none expected", cyc, g_re, g_im);
            end else begin
              e = q.pop_front();
              if (e.cyc != cyc || e.sof != out_sof || e.re != g_re || e.im != g_im) begin
                n_bad++;
                $display("FAIL out_sample: got cyc=%0d sof=%0b re=%0d im=%0d, want cyc=%0d sof=%0b re=%0d im=%0d",
                         cyc, out_sof, g_re, g_im, e.cyc, e.sof, e.re, e.im);
              end
            end
          end
        end
      end
    join_none

    rst = 1; in_valid = 0; in_sof = 0; in_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    drv(0, 0, 0, 0, 0);
    mon_en = 1;
    idle(2);

    // single frame
    ramp(1);
    run_frame(8);
    idle(8);

    // back-to-back frames
    e0 = err_cnt;
    ramp(1);
    run_frame(8);
    ramp(9);
    run_frame(8);
    idle(8);
    chk("b2b_err_cnt", err_cnt, e0);

    // overflow of both operands
    for (int k = 0; k < 8; k++) begin f_re[k] = 64'sd8589934591; f_im[k] = 0; end
    for (int j = 0; j < 4; j++) begin
      s_re[j] = 64'sd17179869182; s_im[j] = 0; d_re[j] = 0; d_im[j] = 0;
    end
    run_frame(8);
    idle(8);

    // in_valid dropped at sample 6
    e0 = err_cnt;
    ramp(1);
    run_frame(6);
    drv(0, 0, 0, 0, 0);
    cbad = cyc;
    idle(8);
    chk("drop_err_cnt", err_cnt, e0 + 1);
    chk("drop_err_cyc", err_cyc, cbad + 1);

    // recovery frame with nonzero imaginary parts
    ramp(1);
    f_im = '{8, 7, 6, 5, 4, 3, 2, 1};
    s_im = '{12, 10, 8, 6};
    d_im = '{4, 4, 4, 4};
    run_frame(8);
    idle(8);

    // synchronous reset mid-BFLY
    ramp(1);
    run_frame(6);
    drv(1, 0, 7, 0, 1);
    drv(0, 0, 0, 0, 1);
    @(negedge clk);
    chk_zero("midrst");
    drv(0, 0, 0, 0, 0);
    idle(2);
    ramp(9);
    run_frame(8);
    idle(8);

    // sof during drain cycle 2 is flagged and ignored
    e0 = err_cnt;
    ramp(1);
    run_frame(8);
    drv(0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0);
    drv(1, 1, 100, 50, 0);
    cbad = cyc;
    drv(1, 0, 200, 60, 0);
    idle(6);
    chk("drain_sof_err_cnt", err_cnt, e0 + 1);
    chk("drain_sof_err_cyc", err_cyc, cbad + 1);
    ramp(9);
    run_frame(8);
    idle(10);

    chk("queue_empty", longint'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
